// File: rtl/lowpass_decimator.sv
// -----------------------------------------------------------------------------
// lowpass_decimator
//
// Turns the 18-bit output of the 31-tap lowpass FIR (y, scaled by 2**SHIFT)
// into 8-bit samples. It keeps one filtered sample in every DECIM and queues
// the kept samples in a small first-word-fall-through FIFO. The FIFO is read
// with a valid/ack handshake by the downstream recorder/storage stage.
//
// Configuration macro:
//   LOWPASS_DECIM_ROUND_EN  defined   : round half up, then saturate above 127
//                           undefined : truncate (filt_in >>> SHIFT)
//   Latency and handshake are the same in both builds.
//
// Parameters:
//   DECIM       keep 1 of every DECIM primed filter outputs (1..16)
//   FIFO_DEPTH  FIFO entries, power of 2 (2..64)
//   SHIFT       coefficient scale exponent
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       synchronous, active-high; overrides every other input
//   ready       sample strobe shared with the FIR (spacing >= 32 clocks)
//   filt_in     signed FIR output y, stable while ready is high
//   out_data    signed head-of-FIFO sample; holds its last value when empty
//   out_valid   FIFO non-empty
//   out_ack     pops the head when out_valid is also high
//   fifo_count  number of entries held
//   overflow    sticky: a kept sample was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module lowpass_decimator #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT      = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ready,
  input  logic [17:0]                   filt_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // DECIM=1 still needs a one-bit phase register so the declaration is legal.
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  // ---------------------------------------------------------------------------
  // Sample conversion: 18-bit scaled FIR output to 8-bit signed sample.
  // ---------------------------------------------------------------------------
`ifdef LOWPASS_DECIM_ROUND_EN
  localparam logic signed [18:0] HALF = 19'sd1 <<< (SHIFT - 1);

  function automatic logic [7:0] convert(input logic [17:0] y);
    logic signed [18:0] sum;
    logic signed [18:0] shifted;
    // One guard bit keeps y + HALF from wrapping at the positive full scale.
    sum     = $signed({y[17], y}) + HALF;
    shifted = sum >>> SHIFT;
    // Rounding can only push the most positive inputs past 127; the most
    // negative input still lands exactly on -128, so only one clamp exists.
    if (shifted > 19'sd127) begin
      return 8'sd127;
    end
    return shifted[7:0];
  endfunction
`else
  function automatic logic [7:0] convert(input logic [17:0] y);
    return y[SHIFT+7:SHIFT];
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Priming, decimation phase and conversion register (edge E0).
  // ---------------------------------------------------------------------------
  logic          primed;
  logic [PW-1:0] phase;
  logic          conv_valid;
  logic [7:0]    conv_data;
  logic          keep;

  // At each ready the FIR presents the result for the previous sample, so the
  // first strobe after reset carries nothing useful and only primes the path.
  assign keep = ready && primed && (phase == '0);

  // NOTE: sequential state is assigned with <= so every register samples the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      primed     <= 1'b0;
      phase      <= '0;
      conv_valid <= 1'b0;
      conv_data  <= '0;
    end else begin
      // conv_valid is a one-cycle strobe: set at E0, cleared at E1.
      conv_valid <= keep;
      if (keep) begin
        conv_data <= convert(filt_in);
      end
      if (ready) begin
        if (!primed) begin
          primed <= 1'b1;
        end else if (phase == PW'(DECIM - 1)) begin
          phase <= '0;
        end else begin
          phase <= phase + PW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO (push at edge E1).
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic          full;
  logic          pop;
  logic          push;
  logic [CW-1:0] count_next;
  logic          head_load;
  logic [7:0]    head_next;

  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign pop        = out_valid && out_ack;
  // A pop on the same edge frees a slot, so a push into a full FIFO still
  // succeeds when the head is being taken.
  assign push       = conv_valid && (!full || pop);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // Next occupancy and next head. out_data is a register rather than a
  // direct memory read so it can hold its last value once the FIFO drains.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    count_next = fifo_count;
    head_load  = 1'b0;
    head_next  = out_data;

    if (push && !pop) begin
      count_next = fifo_count + CW'(1);
    end else if (pop && !push) begin
      count_next = fifo_count - CW'(1);
    end

    if (pop) begin
      if (fifo_count > CW'(1)) begin
        // The entry behind the head is already in memory.
        head_load = 1'b1;
        head_next = mem[rd_ptr_inc];
      end else if (push) begin
        // Last entry leaves as a new one arrives; the new one is not in
        // memory yet, so take it straight from the conversion register.
        head_load = 1'b1;
        head_next = conv_data;
      end
    end else if (push && (fifo_count == '0)) begin
      head_load = 1'b1;
      head_next = conv_data;
    end
  end

  // NOTE: the storage array is not reset; an entry is only ever read after it
  // has been written, so clearing it would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= conv_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      // Pointer widths match log2(FIFO_DEPTH), so increments wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (conv_valid && full && !pop) begin
        overflow <= 1'b1;
      end
      fifo_count <= count_next;
      out_valid  <= (count_next != '0);
      if (head_load) begin
        out_data <= head_next;
      end
    end
  end

endmodule
